// File: rtl/traceback_if.sv
// Direction-memory read port and edit-op stream between the traceback unit and its neighbours.
interface traceback_if #(
  parameter int unsigned ROW_W = 10,
  parameter int unsigned COL_W = 6
) ();
  logic                   mem_rd;
  logic [ROW_W+COL_W-1:0] mem_addr;
  logic [3:0]             mem_data;
  logic [1:0]             op;
  logic                   op_valid;
  logic                   op_ready;
  logic                   op_last;

  modport master (
    output mem_rd,
    output mem_addr,
    input  mem_data,
    output op,
    output op_valid,
    input  op_ready,
    output op_last
  );

  modport slave (
    input  mem_rd,
    input  mem_addr,
    output mem_data,
    input  op,
    input  op_valid,
    output op_ready,
    input  op_last
  );
endinterface

// File: rtl/traceback_unit.sv
// Affine-gap traceback: walks the direction matrices from (row_end, col_end) back to the origin
// and streams the alignment as M/I/D ops in reverse order.
module traceback_unit #(
  parameter int unsigned ROW_W = 10,
  parameter int unsigned COL_W = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [ROW_W-1:0] i_row_end,
  input  logic [COL_W:0]   i_col_end,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [ROW_W+1:0] o_len,
  traceback_if.master      bus
);

  typedef enum logic [2:0] {StIdle, StFetch, StEval, StEmit, StDone} state_e;
  typedef enum logic [1:0] {MatV, MatI, MatD} mat_e;

  localparam logic [1:0] OpM = 2'd0;
  localparam logic [1:0] OpI = 2'd1;
  localparam logic [1:0] OpD = 2'd2;

  state_e           state_q, state_d;
  mat_e             mat_q, mat_d;
  mat_e             nmat_q, nmat_d;
  logic [ROW_W-1:0] r_q, r_d;
  logic [COL_W:0]   c_q, c_d;
  logic [3:0]       word_q, word_d;
  logic             reeval_q, reeval_d;
  logic [1:0]       op_q, op_d;
  logic [ROW_W+1:0] len_q, len_d;
  logic             err_q, err_d;

  logic [3:0]       word;
  logic [ROW_W-1:0] r_m1, r_nx;
  logic [COL_W:0]   c_m1, c_nx;
  logic             last;
  logic             fetch;

  // A V->I/D switch re-evaluates the word already captured instead of re-reading memory.
  assign word = reeval_q ? word_q : bus.mem_data;
  assign r_m1 = r_q - 1'b1;
  assign c_m1 = c_q - 1'b1;

  // Coordinates after the pending op is accepted.
  always_comb begin
    r_nx = r_q;
    c_nx = c_q;
    case (op_q)
      OpM: begin
        r_nx = r_m1;
        c_nx = c_m1;
      end
      OpI:     c_nx = c_m1;
      default: r_nx = r_m1;
    endcase
  end

  assign last = (r_nx == '0) && (c_nx == '0);

  always_comb begin
    state_d  = state_q;
    mat_d    = mat_q;
    nmat_d   = nmat_q;
    r_d      = r_q;
    c_d      = c_q;
    word_d   = word_q;
    reeval_d = reeval_q;
    op_d     = op_q;
    len_d    = len_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          r_d      = i_row_end;
          c_d      = i_col_end;
          mat_d    = MatV;
          nmat_d   = MatV;
          len_d    = '0;
          err_d    = 1'b0;
          reeval_d = 1'b0;
          if ((i_row_end == '0) && (i_col_end == '0)) begin
            state_d = StDone;
          end else if ((i_row_end == '0) || (i_col_end == '0)) begin
            op_d    = (i_col_end != '0) ? OpI : OpD;
            state_d = StEmit;
          end else begin
            state_d = StFetch;
          end
        end
      end
      StFetch: begin
        reeval_d = 1'b0;
        state_d  = StEval;
      end
      StEval: begin
        word_d   = word;
        reeval_d = 1'b1;
        case (mat_q)
          MatV: begin
            case (word[1:0])
              2'd0: begin
                op_d    = OpM;
                nmat_d  = MatV;
                state_d = StEmit;
              end
              2'd1: mat_d = MatI;
              2'd2: mat_d = MatD;
              default: begin
                err_d   = 1'b1;
                state_d = StDone;
              end
            endcase
          end
          MatI: begin
            op_d    = OpI;
            nmat_d  = word[2] ? MatI : MatV;
            state_d = StEmit;
          end
          MatD: begin
            op_d    = OpD;
            nmat_d  = word[3] ? MatD : MatV;
            state_d = StEmit;
          end
          default: begin
            err_d   = 1'b1;
            state_d = StDone;
          end
        endcase
      end
      StEmit: begin
        if (bus.op_ready) begin
          r_d   = r_nx;
          c_d   = c_nx;
          mat_d = nmat_q;
          len_d = len_q + 1'b1;
          if (last) begin
            state_d = StDone;
          end else if ((r_nx == '0) || (c_nx == '0)) begin
            op_d    = (c_nx != '0) ? OpI : OpD;
            state_d = StEmit;
          end else begin
            state_d = StFetch;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      mat_q    <= MatV;
      nmat_q   <= MatV;
      r_q      <= '0;
      c_q      <= '0;
      word_q   <= '0;
      reeval_q <= 1'b0;
      op_q     <= OpM;
      len_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mat_q    <= mat_d;
      nmat_q   <= nmat_d;
      r_q      <= r_d;
      c_q      <= c_d;
      word_q   <= word_d;
      reeval_q <= reeval_d;
      op_q     <= op_d;
      len_q    <= len_d;
      err_q    <= err_d;
    end
  end

  assign fetch        = (state_q == StFetch);
  assign bus.mem_rd   = fetch;
  assign bus.mem_addr = fetch ? {r_m1, c_m1[COL_W-1:0]} : '0;
  assign bus.op       = op_q;
  assign bus.op_valid = (state_q == StEmit);
  assign bus.op_last  = (state_q == StEmit) && last;

  assign o_busy = (state_q != StIdle);
  assign o_done = (state_q == StDone);
  assign o_err  = (state_q == StDone) && err_q;
  assign o_len  = len_q;

endmodule

// File: tb/tb_traceback_unit.sv
// Directed bench for traceback_unit: expected reads and ops are queued at start and checked as
// the unit produces them.
module tb_traceback_unit;
  localparam int unsigned ROW_W = 10;
  localparam int unsigned COL_W = 6;
  localparam logic [1:0] OP_M = 2'd0;
  localparam logic [1:0] OP_I = 2'd1;
  localparam logic [1:0] OP_D = 2'd2;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_start = 1'b0;
  logic [ROW_W-1:0] i_row_end = '0;
  logic [COL_W:0]   i_col_end = '0;
  logic             o_busy;
  logic             o_done;
  logic             o_err;
  logic [ROW_W+1:0] o_len;

  traceback_if #(.ROW_W(ROW_W), .COL_W(COL_W)) bus ();

  traceback_unit #(.ROW_W(ROW_W), .COL_W(COL_W)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_start   (i_start),
    .i_row_end (i_row_end),
    .i_col_end (i_col_end),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_err     (o_err),
    .o_len     (o_len),
    .bus       (bus)
  );

  always #5 i_clk = ~i_clk;

  logic [3:0] mem [0:(1<<(ROW_W+COL_W))-1];
  always @(posedge i_clk) if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];

  int checks = 0;
  int errors = 0;

  logic [2:0]  exp_ops[$];   // {last, op}
  logic [15:0] exp_addr[$];

  int         ncyc = 0;
  int         t0 = 0;
  int         rd_cnt, ops_cnt, done_cnt, err_cnt;
  int         first_rd, first_vld, done_at;
  logic       err_at_done;
  logic [11:0] len_at_done;
  logic       prev_stall = 1'b0;
  logic [2:0] prev_op = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge i_clk) begin
    ncyc++;
    if (!i_rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(bus.op_valid), 32'd1);
        chk("hold_op", 32'({bus.op_last, bus.op}), 32'(prev_op));
      end
      if (bus.mem_rd) begin
        if (rd_cnt == 0) first_rd = ncyc - t0;
        rd_cnt++;
        chk("rd_expected", 32'(exp_addr.size() != 0), 32'd1);
        if (exp_addr.size() != 0) chk("rd_addr", 32'(bus.mem_addr), 32'(exp_addr.pop_front()));
      end
      if (bus.op_valid && first_vld < 0) first_vld = ncyc - t0;
      if (bus.op_valid && bus.op_ready) begin
        ops_cnt++;
        chk("op_expected", 32'(exp_ops.size() != 0), 32'd1);
        if (exp_ops.size() != 0)
          chk("op_value", 32'({bus.op_last, bus.op}), 32'(exp_ops.pop_front()));
      end
      if (o_err) err_cnt++;
      if (o_done) begin
        done_cnt++;
        done_at     = ncyc - t0;
        err_at_done = o_err;
        len_at_done = o_len;
      end
      prev_stall = bus.op_valid && !bus.op_ready;
      prev_op    = {bus.op_last, bus.op};
    end
  end

  task automatic start_run(input int r, input int c);
    @(posedge i_clk); #1;
    rd_cnt = 0; ops_cnt = 0; done_cnt = 0; err_cnt = 0;
    first_rd = -1; first_vld = -1; done_at = -1;
    t0 = ncyc + 1;
    i_start   = 1'b1;
    i_row_end = ROW_W'(r);
    i_col_end = (COL_W+1)'(c);
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (done_cnt == 0 && n < limit) begin
      @(posedge i_clk); #1;
      n++;
    end
    chk("done_seen", 32'(done_cnt), 32'd1);
  endtask

  task automatic wait_valid(input int limit);
    int n = 0;
    while (!bus.op_valid && n < limit) begin
      @(posedge i_clk); #1;
      n++;
    end
    chk("valid_seen", 32'(bus.op_valid), 32'd1);
  endtask

  task automatic check_run(input string tag, input int done_e, input int len_e, input int rd_e,
                           input int err_e);
    chk({tag, "_done_at"}, 32'(done_at), 32'(done_e));
    chk({tag, "_len"}, 32'(len_at_done), 32'(len_e));
    chk({tag, "_reads"}, 32'(rd_cnt), 32'(rd_e));
    chk({tag, "_err"}, 32'(err_at_done), 32'(err_e));
    chk({tag, "_left"}, 32'(exp_ops.size() + exp_addr.size()), 32'd0);
    chk({tag, "_idle"}, 32'({o_busy, o_done}), 32'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_flags"},
        32'({o_busy, o_done, o_err, bus.mem_rd, bus.op_valid, bus.op_last}), 32'd0);
    chk({tag, "_len"}, 32'(o_len), 32'd0);
    chk({tag, "_addr"}, 32'(bus.mem_addr), 32'd0);
    chk({tag, "_op"}, 32'(bus.op), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < (1 << (ROW_W + COL_W)); i++) mem[i] = 4'h0;
    bus.op_ready = 1'b0;
    rd_cnt = 0; ops_cnt = 0; done_cnt = 0; err_cnt = 0;
    first_rd = -1; first_vld = -1; done_at = -1;

    repeat (2) @(posedge i_clk);
    #1;
    check_zero_outputs("reset");
    i_rst_n = 1'b1;

    // Pure diagonal (2,2)
    exp_addr.push_back(16'd65); exp_addr.push_back(16'd0);
    exp_ops.push_back({1'b0, OP_M}); exp_ops.push_back({1'b1, OP_M});
    bus.op_ready = 1'b1;
    start_run(2, 2);
    wait_done(50);
    check_run("diag", 7, 2, 2, 0);
    chk("diag_first_rd", 32'(first_rd), 32'd1);
    chk("diag_first_vld", 32'(first_vld), 32'd3);

    // Affine insertion run (1,3)
    mem[2] = 4'h5; mem[1] = 4'h0; mem[0] = 4'h0;
    exp_addr.push_back(16'd2); exp_addr.push_back(16'd1); exp_addr.push_back(16'd0);
    exp_ops.push_back({1'b0, OP_I}); exp_ops.push_back({1'b0, OP_I});
    exp_ops.push_back({1'b1, OP_M});
    start_run(1, 3);
    wait_done(50);
    check_run("affine", 11, 3, 3, 0);
    chk("affine_first_vld", 32'(first_vld), 32'd4);

    // Boundary only (3,0)
    for (int i = 0; i < 3; i++) exp_ops.push_back({(i == 2), OP_D});
    start_run(3, 0);
    wait_done(20);
    check_run("bnd", 4, 3, 0, 0);
    chk("bnd_first_vld", 32'(first_vld), 32'd1);

    // Zero length
    start_run(0, 0);
    wait_done(20);
    check_run("zero", 1, 0, 0, 0);
    chk("zero_ops", 32'(ops_cnt), 32'd0);

    // Backpressure on the first diagonal op
    mem[2] = 4'h0;
    exp_addr.push_back(16'd65); exp_addr.push_back(16'd0);
    exp_ops.push_back({1'b0, OP_M}); exp_ops.push_back({1'b1, OP_M});
    bus.op_ready = 1'b0;
    start_run(2, 2);
    wait_valid(20);
    repeat (5) @(posedge i_clk);
    #1;
    chk("bp_one_read", 32'(rd_cnt), 32'd1);
    chk("bp_valid", 32'(bus.op_valid), 32'd1);
    chk("bp_op", 32'(bus.op), 32'(OP_M));
    bus.op_ready = 1'b1;
    wait_done(50);
    check_run("bp", 12, 2, 2, 0);

    // Illegal direction word
    mem[0] = 4'h3;
    exp_addr.push_back(16'd0);
    start_run(1, 1);
    wait_done(20);
    check_run("illegal", 3, 0, 1, 1);
    chk("illegal_ops", 32'(ops_cnt), 32'd0);
    chk("illegal_err_pulses", 32'(err_cnt), 32'd1);
    mem[0] = 4'h0;

    // Reset during the second EMIT of the affine sequence
    mem[2] = 4'h5; mem[1] = 4'h0; mem[0] = 4'h0;
    exp_addr.push_back(16'd2); exp_addr.push_back(16'd1); exp_addr.push_back(16'd0);
    exp_ops.push_back({1'b0, OP_I}); exp_ops.push_back({1'b0, OP_I});
    exp_ops.push_back({1'b1, OP_M});
    bus.op_ready = 1'b1;
    start_run(1, 3);
    for (int n = 0; n < 20 && ops_cnt == 0; n++) begin
      @(posedge i_clk); #1;
    end
    bus.op_ready = 1'b0;
    chk("rst_mid_len_before", 32'(o_len), 32'd1);
    wait_valid(20);
    i_rst_n = 1'b0;
    #1;
    check_zero_outputs("rst_mid");
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_mid_no_done", 32'(done_cnt), 32'd0);
    exp_ops.delete();
    exp_addr.delete();
    i_rst_n = 1'b1;
    bus.op_ready = 1'b1;
    exp_addr.push_back(16'd2); exp_addr.push_back(16'd1); exp_addr.push_back(16'd0);
    exp_ops.push_back({1'b0, OP_I}); exp_ops.push_back({1'b0, OP_I});
    exp_ops.push_back({1'b1, OP_M});
    start_run(1, 3);
    wait_done(50);
    check_run("rerun", 11, 3, 3, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
